tx_fifo_scheduler: RTL and testbench
====================================

TX_FIFO_SCHEDULER -- requirements
Module: tx_fifo_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, data bits per entry.
- GAP_CYCLES, 2, idle Clock cycles inserted after each completed byte (0 allowed).
- TIMEOUT_CYCLES, 20000, maximum WAIT cycles before abort (at least 1).
- COUNT_WIDTH, 16, width of ByteCount.
REQ-002 Clock/reset decision SHALL be exactly: one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name direction width meaning.
- Clock  input  1  sole clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high.
- Enable  input  1  permits starting new bytes.
- Flush  input  1  requests discard of all FIFO contents.
- FifoEmpty  input  1  FIFO empty flag.
- FifoReadData  input  WIDTH  FIFO head entry, combinationally valid.
- FifoRead  output  1  FIFO pop strobe.
- TxStart  output  1  one-cycle start pulse to transmitter.
- TxData  output  WIDTH  byte presented to transmitter.
- TxDone  input  1  one-cycle pulse: transmitter finished byte.
- Busy  output  1  high whenever state is not IDLE.
- Error  output  1  sticky timeout flag.
- ByteCount  output  COUNT_WIDTH  bytes completed since reset.

Function
REQ-010 FSM states SHALL be IDLE, START, WAIT, GAP and FLUSH; the state is registered.
REQ-011 In IDLE, when Flush=1 and FifoEmpty=0: FifoRead=1 and the next state is FLUSH; Flush has priority over Enable.
REQ-012 In IDLE, when Flush=0, Enable=1 and FifoEmpty=0: FifoRead=1 the same cycle, TxData<=FifoReadData on that edge, and the next state is START.
REQ-013 FifoRead SHALL be combinational from the state and inputs, and SHALL never assert when FifoEmpty=1.
REQ-014 In START: TxStart=1 for exactly one cycle; the next state is WAIT; the wait counter is cleared.
REQ-015 Latency: FifoRead in cycle N SHALL be followed by TxStart in cycle N+1.
REQ-016 TxData SHALL hold its value from capture until the next capture.
REQ-017 In WAIT, on TxDone=1: ByteCount increments by 1 (modulo 2^COUNT_WIDTH); the next state is GAP when GAP_CYCLES>0, else IDLE.
REQ-018 In WAIT without TxDone: the counter increments; after TIMEOUT_CYCLES cycles it sets Error=1 and the next state is IDLE; ByteCount is not incremented.
REQ-019 TxDone in any state other than WAIT SHALL be ignored.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; in GAP, FifoRead=0 and TxStart=0.
REQ-021 In FLUSH: FifoRead=1 on every cycle with FifoEmpty=0; the state becomes IDLE in the first cycle FifoEmpty=1; TxStart never asserts.
REQ-022 Deasserting Flush in FLUSH SHALL not stop the flush before the FIFO is empty.
REQ-023 Deasserting Enable in START, WAIT or GAP SHALL let the current byte complete; no new byte starts while Enable=0.
REQ-024 Asserting Flush during START, WAIT or GAP SHALL take effect only on return to IDLE.
REQ-025 Busy SHALL be high when state is not IDLE.
REQ-026 Error SHALL remain set until Reset; it SHALL not block further operation.
REQ-027 Byte-to-byte spacing SHALL be at least 1 + GAP_CYCLES idle cycles after TxDone, plus 1 IDLE cycle.

Reset
REQ-030 When Reset=1 at a rising edge, the state SHALL become IDLE and the outputs SHALL be: TxData=0, ByteCount=0, Error=0, wait/gap counters=0.
REQ-031 During reset: FifoRead=0, TxStart=0, Busy=0.
REQ-032 Reset SHALL override any state mid-operation, including WAIT and FLUSH; a pending byte is abandoned and not counted.

Verification
REQ-040 Single byte: FIFO holds 8'hA5, Enable=1, TxDone returned 10 cycles after TxStart -> FifoRead for 1 cycle, TxStart the next cycle, TxData=8'hA5, ByteCount=1, Busy low 3 cycles after TxDone (GAP_CYCLES=2).
REQ-041 Back-to-back: FIFO holds 8'h01, 8'h02, 8'h03 -> three TxStart pulses in that data order, each separated per REQ-027, ByteCount=3, Error=0.
REQ-042 Flush: FIFO holds 4 entries, Flush=1 in IDLE -> FifoRead high 4 consecutive cycles, no TxStart, IDLE when FifoEmpty=1, ByteCount unchanged.
REQ-043 Timeout: TIMEOUT_CYCLES=8, TxDone never returned -> Error=1 after 8 WAIT cycles, IDLE, ByteCount=0; the next byte still transmits normally.
REQ-044 Reset mid-WAIT: assert Reset for 1 cycle during WAIT -> IDLE, ByteCount=0, Busy=0; a late TxDone is ignored.
REQ-045 Wrap: COUNT_WIDTH=2 with 5 bytes sent -> ByteCount=1; Enable dropped mid-WAIT -> byte completes, no further FifoRead.

Source files
------------

// File: rtl/tx_fifo_scheduler.sv
// tx_fifo_scheduler: pops bytes from a FIFO and hands them one at a time to a
// transmitter, waits for completion (with timeout), inserts an idle gap after
// each completed byte, and can drain the FIFO on request.
module tx_fifo_scheduler #(
    parameter int WIDTH          = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   Flush,
    input  logic                   FifoEmpty,
    input  logic [WIDTH-1:0]       FifoReadData,
    output logic                   FifoRead,
    output logic                   TxStart,
    output logic [WIDTH-1:0]       TxData,
    input  logic                   TxDone,
    output logic                   Busy,
    output logic                   Error,
    output logic [COUNT_WIDTH-1:0] ByteCount
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    // Pop strobe: IDLE pops to start a byte or a flush, FLUSH pops until empty.
    always_comb begin
        FifoRead = 1'b0;
        if (!Reset && !FifoEmpty) begin
            case (state)
                IDLE:    FifoRead = Flush | Enable;
                FLUSH:   FifoRead = 1'b1;
                default: FifoRead = 1'b0;
            endcase
        end
    end

    // Status strobes decode the registered state; held low while in reset.
    assign TxStart = !Reset && (state == START);
    assign Busy    = !Reset && (state != IDLE);

    // Scheduler FSM, data capture, byte counter, wait/gap timers, sticky error.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            TxData    <= '0;
            ByteCount <= '0;
            Error     <= 1'b0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!FifoEmpty) begin
                        if (Flush) begin
                            state <= FLUSH;
                        end else if (Enable) begin
                            TxData <= FifoReadData;
                            state  <= START;
                        end
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (TxDone) begin
                        ByteCount <= ByteCount + COUNT_WIDTH'(1);
                        gap_cnt   <= '0;
                        state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                FLUSH: begin
                    if (FifoEmpty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_fifo_scheduler.sv
// Bench for tx_fifo_scheduler: a FIFO model and transmitter responder drive
// two instances (default timing, and short timeout with a 2-bit counter);
// one instance is active at a time. Expected bytes go into a scoreboard queue
// that a monitor pops on every TxStart.
module tb_tx_fifo_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic enable;
    logic flush;
    logic tx_done = 1'b0;
    logic sel;

    // FIFO model
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_head  = mem[rd_ptr[5:0]];

    // Instance A: defaults
    logic        a_rd, a_start, a_busy, a_err;
    logic [7:0]  a_data;
    logic [15:0] a_cnt;
    // Instance B: short timeout, 2-bit byte counter
    logic        b_rd, b_start, b_busy, b_err;
    logic [7:0]  b_data;
    logic [1:0]  b_cnt;

    tx_fifo_scheduler #(.WIDTH(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20000), .COUNT_WIDTH(16)) dut_a (
        .Clock(clk), .Reset(rst), .Enable(enable & ~sel), .Flush(flush & ~sel),
        .FifoEmpty(fifo_empty | sel), .FifoReadData(fifo_head), .FifoRead(a_rd),
        .TxStart(a_start), .TxData(a_data), .TxDone(tx_done & ~sel),
        .Busy(a_busy), .Error(a_err), .ByteCount(a_cnt)
    );

    tx_fifo_scheduler #(.WIDTH(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8), .COUNT_WIDTH(2)) dut_b (
        .Clock(clk), .Reset(rst), .Enable(enable & sel), .Flush(flush & sel),
        .FifoEmpty(fifo_empty | ~sel), .FifoReadData(fifo_head), .FifoRead(b_rd),
        .TxStart(b_start), .TxData(b_data), .TxDone(tx_done & sel),
        .Busy(b_busy), .Error(b_err), .ByteCount(b_cnt)
    );

    logic        m_rd, m_start, m_busy, m_err;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;
    assign m_rd    = sel ? b_rd    : a_rd;
    assign m_start = sel ? b_start : a_start;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_err   = sel ? b_err   : a_err;
    assign m_data  = sel ? b_data  : a_data;
    assign m_cnt   = sel ? {14'd0, b_cnt} : a_cnt;

    int cyc = 0;
    int rd_total = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_rd) begin
            rd_total <= rd_total + 1;
            if (!fifo_empty) rd_ptr <= rd_ptr + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] exp_q [$];
    int         start_log [$];
    int         done_log [$];

    // Transmitter responder: TxDone comes done_delay cycles after TxStart.
    logic auto_done  = 1'b0;
    int   done_delay = 10;
    int   cd         = 0;
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                tx_done = 1'b1;
                done_log.push_back(cyc);
            end
        end
        if (m_start && auto_done) cd = done_delay;
    end

    // Monitor: scoreboard pop on TxStart, start latency, no pop from empty FIFO.
    logic       pend_start = 1'b0;
    logic [7:0] exp_byte;
    always @(negedge clk) begin
        if (pend_start) check("start_latency", m_start, 1);
        pend_start = m_rd && !m_busy && enable && !flush;
        if (m_rd) check("read_nonempty", fifo_empty, 0);
        if (m_start) begin
            start_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_txstart", m_start, 0);
            end else begin
                exp_byte = exp_q.pop_front();
                check("tx_data", m_data, exp_byte);
            end
        end
    end

    task automatic push_raw(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr++;
    endtask

    task automatic push_tx(input logic [7:0] d);
        push_raw(d);
        exp_q.push_back(d);
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        for (int i = 0; i < 200 && m_busy !== lvl; i++) @(negedge clk);
        check(name, m_busy, lvl);
    endtask

    task automatic wait_dones(input int target, input string name);
        for (int i = 0; i < 400 && !(done_log.size() >= target && !m_busy); i++) @(negedge clk);
        check(name, done_log.size(), target);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required finish before 300000");
        $fatal(1, "watchdog");
    end

    int r0, s0, nb, busy_cycles;

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; sel = 1'b0;
        @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_txstart", a_start, 0);
        check("rst_txdata", a_data, 0);
        check("rst_count", a_cnt, 0);
        check("rst_error", a_err, 0);
        check("rst_b_busy", b_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single byte, TxDone 10 cycles after TxStart
        auto_done = 1'b1; done_delay = 10;
        r0 = rd_total;
        push_tx(8'hA5);
        enable = 1'b1;
        wait_busy(1'b1, "single_busy_rise");
        wait_busy(1'b0, "single_busy_fall");
        check("single_done_to_idle", cyc - done_log[$], 3);
        check("single_start_to_done", done_log[$] - start_log[$], 10);
        check("single_reads", rd_total - r0, 1);
        check("single_count", m_cnt, 1);
        check("single_txdata_held", m_data, 8'hA5);
        enable = 1'b0;
        @(negedge clk);

        // Back-to-back three bytes
        done_delay = 4;
        nb = done_log.size();
        push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
        enable = 1'b1;
        wait_dones(nb + 3, "b2b_dones");
        check("b2b_spacing1", start_log[$-1] - done_log[$-2], 4);
        check("b2b_spacing2", start_log[$] - done_log[$-1], 4);
        check("b2b_count", m_cnt, 4);
        check("b2b_error", m_err, 0);
        enable = 1'b0;
        @(negedge clk);

        // Flush four entries; Flush released after one cycle
        r0 = rd_total;
        push_raw(8'h11); push_raw(8'h22); push_raw(8'h33); push_raw(8'h44);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20 && m_busy; i++) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("flush_reads", rd_total - r0, 4);
        check("flush_cycles", busy_cycles, 4);
        check("flush_empty", fifo_empty, 1);
        check("flush_busy", m_busy, 0);
        check("flush_count", m_cnt, 4);

        // Reset during WAIT; the late TxDone must be ignored
        done_delay = 10;
        push_tx(8'h5A);
        enable = 1'b1;
        wait_busy(1'b1, "rstwait_busy_rise");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwait_read_in_reset", m_rd, 0);
        check("rstwait_start_in_reset", m_start, 0);
        check("rstwait_busy_in_reset", m_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        check("rstwait_count", m_cnt, 0);
        check("rstwait_txdata", m_data, 0);
        repeat (10) @(negedge clk);
        check("rstwait_late_done_count", m_cnt, 0);
        check("rstwait_late_done_busy", m_busy, 0);
        enable = 1'b0;
        @(negedge clk);

        // Timeout on instance B (TIMEOUT_CYCLES=8), then recovery
        sel = 1'b1;
        auto_done = 1'b0;
        push_tx(8'hC3);
        enable = 1'b1;
        wait_busy(1'b1, "tmo_busy_rise");
        s0 = cyc;
        for (int i = 0; i < 50 && !m_err; i++) @(negedge clk);
        check("tmo_error_cycle", cyc - s0, 9);
        check("tmo_error", m_err, 1);
        check("tmo_busy", m_busy, 0);
        check("tmo_count", m_cnt, 0);
        auto_done = 1'b1; done_delay = 3;
        push_tx(8'h3C);
        wait_busy(1'b1, "tmo_next_busy_rise");
        wait_busy(1'b0, "tmo_next_busy_fall");
        check("tmo_next_count", m_cnt, 1);
        check("tmo_error_sticky", m_err, 1);
        enable = 1'b0;

        // Counter wrap: 5 bytes into a 2-bit counter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wrap_error_cleared", m_err, 0);
        done_delay = 2;
        nb = done_log.size();
        push_tx(8'h10); push_tx(8'h20); push_tx(8'h30); push_tx(8'h40); push_tx(8'h50);
        enable = 1'b1;
        wait_dones(nb + 5, "wrap_dones");
        check("wrap_count", m_cnt, 1);

        // Enable dropped mid-WAIT: byte completes, nothing further popped
        enable = 1'b0;
        done_delay = 4;
        push_tx(8'h77);
        push_raw(8'h88);
        enable = 1'b1;
        wait_busy(1'b1, "endrop_busy_rise");
        @(negedge clk);
        enable = 1'b0;
        wait_busy(1'b0, "endrop_busy_fall");
        check("endrop_count", m_cnt, 2);
        r0 = rd_total;
        repeat (10) @(negedge clk);
        check("endrop_no_reads", rd_total - r0, 0);
        check("endrop_fifo_level", wr_ptr - rd_ptr, 1);
        flush = 1'b1;
        wait_busy(1'b1, "cleanup_flush_rise");
        flush = 1'b0;
        wait_busy(1'b0, "cleanup_flush_fall");
        check("cleanup_empty", fifo_empty, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
